// File: rtl/lsu_bus_master.sv
// Single-outstanding load/store bus master.
// Accepts one upstream command at a time, checks its alignment, issues a
// one-cycle request to the device, waits (bounded) for a response, and
// returns a one-cycle completion with the formatted load data or an error.
module lsu_bus_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  // upstream command
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_len,
  input  logic        cmd_wen,
  input  logic [31:0] cmd_wdata,
  input  logic        cmd_signed,
  // device request
  output logic        out_req_valid,
  output logic [31:0] out_req_bits_addr,
  output logic [1:0]  out_req_bits_len,
  output logic [31:0] out_req_bits_data,
  output logic        out_req_bits_func,
  output logic [3:0]  out_req_bits_strb,
  // device response
  input  logic        out_resp_valid,
  input  logic [31:0] out_resp_bits_data,
  // upstream completion
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic        ready_q, ready_d;   // low until the first edge after reset release
  logic [31:0] addr_q, addr_d;
  logic [1:0]  len_q, len_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic        signed_q, signed_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        misaligned;
  logic [31:0] resp_shifted;
  logic [31:0] load_data;
  logic        req_active;

  // Alignment check on the incoming command (len=3 is never legal)
  always_comb begin
    misaligned = (cmd_len == 2'd3)
              || ((cmd_len == 2'd1) && cmd_addr[0])
              || ((cmd_len == 2'd2) && (cmd_addr[1:0] != 2'b00));
  end

  // Right-justify the response lane, then truncate and sign/zero-extend
  always_comb begin
    resp_shifted = out_resp_bits_data >> {addr_q[1:0], 3'b000};
    case (len_q)
      2'd0:    load_data = {{24{signed_q & resp_shifted[7]}}, resp_shifted[7:0]};
      2'd1:    load_data = {{16{signed_q & resp_shifted[15]}}, resp_shifted[15:0]};
      default: load_data = resp_shifted;
    endcase
  end

  // Next-state logic: IDLE -> (REQ -> WAIT ->) DONE -> IDLE
  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b1;
    addr_d   = addr_q;
    len_d    = len_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    signed_d = signed_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d   = cmd_addr;
          len_d    = cmd_len;
          wen_d    = cmd_wen;
          wdata_d  = cmd_wdata;
          signed_d = cmd_signed;
          rdata_d  = '0;
          cnt_d    = '0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d   = 10'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // a response in the final counted cycle still beats the timeout
        if (out_resp_valid) begin
          rdata_d = wen_q ? 32'd0 : load_data;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (cnt_q >= TIMEOUT_CNT) begin
          rdata_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and transaction registers, asynchronously cleared
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      signed_q <= signed_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Request outputs are driven only during REQ and zero otherwise
  always_comb begin
    req_active        = (state_q == S_REQ);
    out_req_valid     = req_active;
    out_req_bits_addr = req_active ? addr_q : 32'd0;
    out_req_bits_len  = req_active ? len_q : 2'd0;
    out_req_bits_func = req_active & wen_q;
    out_req_bits_data = '0;
    out_req_bits_strb = '0;
    if (req_active && wen_q) begin
      out_req_bits_data = wdata_q << {addr_q[1:0], 3'b000};
      case (len_q)
        2'd0:    out_req_bits_strb = 4'b0001 << addr_q[1:0];
        2'd1:    out_req_bits_strb = 4'b0011 << addr_q[1:0];
        default: out_req_bits_strb = 4'b1111;
      endcase
    end
  end

  // Upstream handshake and completion outputs
  always_comb begin
    cmd_ready = (state_q == S_IDLE) && ready_q;
    rsp_valid = (state_q == S_DONE);
    rsp_data  = rsp_valid ? rdata_q : 32'd0;
    rsp_err   = rsp_valid & err_q;
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master (TIMEOUT_CYCLES=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_lsu_bus_master;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_len;
  logic        cmd_wen;
  logic [31:0] cmd_wdata;
  logic        cmd_signed;
  logic        out_req_valid;
  logic [31:0] out_req_bits_addr;
  logic [1:0]  out_req_bits_len;
  logic [31:0] out_req_bits_data;
  logic        out_req_bits_func;
  logic [3:0]  out_req_bits_strb;
  logic        out_resp_valid;
  logic [31:0] out_resp_bits_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  lsu_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_addr           (cmd_addr),
    .cmd_len            (cmd_len),
    .cmd_wen            (cmd_wen),
    .cmd_wdata          (cmd_wdata),
    .cmd_signed         (cmd_signed),
    .out_req_valid      (out_req_valid),
    .out_req_bits_addr  (out_req_bits_addr),
    .out_req_bits_len   (out_req_bits_len),
    .out_req_bits_data  (out_req_bits_data),
    .out_req_bits_func  (out_req_bits_func),
    .out_req_bits_strb  (out_req_bits_strb),
    .out_resp_valid     (out_resp_valid),
    .out_resp_bits_data (out_resp_bits_data),
    .rsp_valid          (rsp_valid),
    .rsp_data           (rsp_data),
    .rsp_err            (rsp_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic set_cmd(input logic [31:0] a, input logic [1:0] l, input logic w,
                         input logic [31:0] d, input logic s);
    cmd_valid  = 1'b1;
    cmd_addr   = a;
    cmd_len    = l;
    cmd_wen    = w;
    cmd_wdata  = d;
    cmd_signed = s;
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_wen = 1'b0;
    cmd_wdata = '0; cmd_signed = 1'b0; out_resp_valid = 1'b0; out_resp_bits_data = '0;
    #1 reset = 1'b1;
    #1;
    vec_cnt++;
    if ({cmd_ready, out_req_valid, rsp_valid, rsp_err} !== 4'b0000) begin
      miss_cnt++;
      $display("FAIL reset_ctrl: got %b expected 0000", {cmd_ready, out_req_valid, rsp_valid, rsp_err});
    end
    vec_cnt++;
    if ({out_req_bits_addr, out_req_bits_data, out_req_bits_strb, out_req_bits_len, out_req_bits_func, rsp_data} !== '0) begin
      miss_cnt++;
      $display("FAIL reset_data: req addr %h data %h rsp %h expected all 0", out_req_bits_addr, out_req_bits_data, rsp_data);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    vec_cnt++;
    if (cmd_ready !== 1'b0) begin
      miss_cnt++;
      $display("FAIL reset_ready_early: got %b expected 0", cmd_ready);
    end
    @(negedge clock);
    vec_cnt++;
    if (cmd_ready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL reset_ready_after_edge: got %b expected 1", cmd_ready);
    end
    $display("txn reset: released, cmd_ready=%b", cmd_ready);
  endtask

  task automatic test_store_byte();
    set_cmd(32'h0000_1003, 2'd0, 1'b1, 32'h0000_00AB, 1'b0);
    vec_cnt++;
    if (cmd_ready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL stb_ready: got %b expected 1", cmd_ready);
    end
    @(negedge clock);
    cmd_valid = 1'b0;
    vec_cnt++;
    if ({out_req_valid, out_req_bits_func, out_req_bits_strb, out_req_bits_len} !== {1'b1, 1'b1, 4'b1000, 2'd0}) begin
      miss_cnt++;
      $display("FAIL stb_req_ctrl: valid %b func %b strb %b len %0d expected 1 1 1000 0",
               out_req_valid, out_req_bits_func, out_req_bits_strb, out_req_bits_len);
    end
    vec_cnt++;
    if ({out_req_bits_addr, out_req_bits_data} !== {32'h0000_1003, 32'hAB00_0000}) begin
      miss_cnt++;
      $display("FAIL stb_req_data: addr %h data %h expected 00001003 ab000000", out_req_bits_addr, out_req_bits_data);
    end
    @(negedge clock);
    vec_cnt++;
    if ({out_req_valid, out_req_bits_strb, out_req_bits_data, out_req_bits_addr} !== '0) begin
      miss_cnt++;
      $display("FAIL stb_req_one_cycle: valid %b strb %b data %h addr %h expected zeros",
               out_req_valid, out_req_bits_strb, out_req_bits_data, out_req_bits_addr);
    end
    out_resp_valid = 1'b1;
    out_resp_bits_data = 32'h1234_5678;
    @(negedge clock);
    out_resp_valid = 1'b0;
    vec_cnt++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h0}) begin
      miss_cnt++;
      $display("FAIL stb_rsp: valid %b err %b data %h expected 1 0 00000000", rsp_valid, rsp_err, rsp_data);
    end
    @(negedge clock);
    vec_cnt++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      miss_cnt++;
      $display("FAIL stb_rsp_one_cycle: rsp_valid %b cmd_ready %b expected 0 1", rsp_valid, cmd_ready);
    end
    $display("txn store byte @1003: rsp_err=%b", rsp_err);
  endtask

  task automatic test_loads();
    logic [31:0] t_addr [6] = '{32'h2002, 32'h2002, 32'h0011, 32'h0040, 32'h0003, 32'h0000};
    logic [1:0]  t_len  [6] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1};
    logic        t_sgn  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_resp [6] = '{32'h8001_1234, 32'h8001_1234, 32'h0000_9A00, 32'hDEAD_BEEF, 32'hF000_0000, 32'h0001_7FFF};
    logic [31:0] t_exp  [6] = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FF9A, 32'hDEAD_BEEF, 32'h0000_00F0, 32'h0000_7FFF};
    for (int i = 0; i < 6; i++) begin
      set_cmd(t_addr[i], t_len[i], 1'b0, 32'hFFFF_FFFF, t_sgn[i]);
      @(negedge clock);
      cmd_valid = 1'b0;
      vec_cnt++;
      if ({out_req_valid, out_req_bits_func, out_req_bits_strb, out_req_bits_data, out_req_bits_addr, out_req_bits_len}
          !== {1'b1, 1'b0, 4'b0000, 32'h0, t_addr[i], t_len[i]}) begin
        miss_cnt++;
        $display("FAIL load_req[%0d]: valid %b func %b strb %b data %h addr %h len %0d expected 1 0 0000 00000000 %h %0d",
                 i, out_req_valid, out_req_bits_func, out_req_bits_strb, out_req_bits_data,
                 out_req_bits_addr, out_req_bits_len, t_addr[i], t_len[i]);
      end
      @(negedge clock);
      out_resp_valid = 1'b1;
      out_resp_bits_data = t_resp[i];
      @(negedge clock);
      out_resp_valid = 1'b0;
      vec_cnt++;
      if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, t_exp[i]}) begin
        miss_cnt++;
        $display("FAIL load_rsp[%0d]: valid %b err %b data %h expected 1 0 %h", i, rsp_valid, rsp_err, rsp_data, t_exp[i]);
      end
      @(negedge clock);
      $display("txn load %0d @%h len %0d signed %b: rsp_data=%h", i, t_addr[i], t_len[i], t_sgn[i], t_exp[i]);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] t_addr [4] = '{32'h3001, 32'h0005, 32'h0004, 32'h0002};
    logic [1:0]  t_len  [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    logic        t_wen  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      set_cmd(t_addr[i], t_len[i], t_wen[i], 32'h5555_AAAA, 1'b1);
      @(negedge clock);
      cmd_valid = 1'b0;
      vec_cnt++;
      if ({out_req_valid, rsp_valid, rsp_err, rsp_data} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
        miss_cnt++;
        $display("FAIL misalign_rsp[%0d]: req_valid %b rsp_valid %b err %b data %h expected 0 1 1 00000000",
                 i, out_req_valid, rsp_valid, rsp_err, rsp_data);
      end
      @(negedge clock);
      vec_cnt++;
      if ({out_req_valid, rsp_valid, cmd_ready} !== 3'b001) begin
        miss_cnt++;
        $display("FAIL misalign_after[%0d]: req_valid %b rsp_valid %b cmd_ready %b expected 0 0 1",
                 i, out_req_valid, rsp_valid, cmd_ready);
      end
      $display("txn misaligned %0d @%h len %0d: rsp_err=1 expected", i, t_addr[i], t_len[i]);
    end
  endtask

  task automatic test_timeout();
    // device never answers: 4 WAIT cycles then error
    set_cmd(32'h0000_0500, 2'd2, 1'b0, 32'h0, 1'b0);
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      @(negedge clock);
      vec_cnt++;
      if ({rsp_valid, out_req_valid} !== 2'b00) begin
        miss_cnt++;
        $display("FAIL timeout_wait[%0d]: rsp_valid %b req_valid %b expected 0 0", w, rsp_valid, out_req_valid);
      end
    end
    @(negedge clock);
    vec_cnt++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 32'h0}) begin
      miss_cnt++;
      $display("FAIL timeout_rsp: valid %b err %b data %h expected 1 1 00000000", rsp_valid, rsp_err, rsp_data);
    end
    // late response lands in DONE and IDLE and must be dropped
    out_resp_valid = 1'b1;
    out_resp_bits_data = 32'hFFFF_FFFF;
    @(negedge clock);
    @(negedge clock);
    out_resp_valid = 1'b0;
    vec_cnt++;
    if ({rsp_valid, out_req_valid, cmd_ready} !== 3'b001) begin
      miss_cnt++;
      $display("FAIL timeout_late_resp: rsp_valid %b req_valid %b cmd_ready %b expected 0 0 1",
               rsp_valid, out_req_valid, cmd_ready);
    end
    $display("txn load @500 timed out");
    // following store proceeds normally
    set_cmd(32'h0000_0602, 2'd1, 1'b1, 32'h0000_BEEF, 1'b0);
    @(negedge clock);
    cmd_valid = 1'b0;
    vec_cnt++;
    if ({out_req_valid, out_req_bits_strb, out_req_bits_data} !== {1'b1, 4'b1100, 32'hBEEF_0000}) begin
      miss_cnt++;
      $display("FAIL post_timeout_req: valid %b strb %b data %h expected 1 1100 beef0000",
               out_req_valid, out_req_bits_strb, out_req_bits_data);
    end
    @(negedge clock);
    out_resp_valid = 1'b1;
    @(negedge clock);
    out_resp_valid = 1'b0;
    vec_cnt++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h0}) begin
      miss_cnt++;
      $display("FAIL post_timeout_rsp: valid %b err %b data %h expected 1 0 00000000", rsp_valid, rsp_err, rsp_data);
    end
    @(negedge clock);
    $display("txn store half @602 after timeout");
  endtask

  task automatic test_resp_at_timeout();
    // response in the 4th (last) WAIT cycle wins over the timeout
    set_cmd(32'h0000_0700, 2'd2, 1'b0, 32'h0, 1'b0);
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clock);
    out_resp_valid = 1'b1;
    out_resp_bits_data = 32'h0BAD_F00D;
    @(negedge clock);
    out_resp_valid = 1'b0;
    vec_cnt++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin
      miss_cnt++;
      $display("FAIL resp_at_timeout: valid %b err %b data %h expected 1 0 0badf00d", rsp_valid, rsp_err, rsp_data);
    end
    @(negedge clock);
    $display("txn load @700 answered on last wait cycle");
  endtask

  task automatic test_reset_in_wait();
    int seen_rsp = 0;
    set_cmd(32'h0000_0800, 2'd2, 1'b0, 32'h0, 1'b0);
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    vec_cnt++;
    if ({cmd_ready, out_req_valid, rsp_valid, rsp_err, rsp_data, out_req_bits_addr} !== '0) begin
      miss_cnt++;
      $display("FAIL reset_in_wait: ready %b req %b rsp %b err %b data %h addr %h expected zeros",
               cmd_ready, out_req_valid, rsp_valid, rsp_err, rsp_data, out_req_bits_addr);
    end
    @(negedge clock);
    out_resp_valid = 1'b1;
    reset = 1'b0;
    #1;
    vec_cnt++;
    if (cmd_ready !== 1'b0) begin
      miss_cnt++;
      $display("FAIL reset_in_wait_ready_early: got %b expected 0", cmd_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      out_resp_valid = 1'b0;
      if (rsp_valid === 1'b1) seen_rsp++;
      if (c == 0) begin
        vec_cnt++;
        if (cmd_ready !== 1'b1) begin
          miss_cnt++;
          $display("FAIL reset_in_wait_ready: got %b expected 1", cmd_ready);
        end
      end
    end
    vec_cnt++;
    if (seen_rsp != 0) begin
      miss_cnt++;
      $display("FAIL reset_in_wait_no_rsp: saw %0d rsp_valid cycles expected 0", seen_rsp);
    end
    $display("txn load @800 abandoned by reset");
  endtask

  task automatic test_back_to_back();
    int   reqs = 0, rsps = 0, accepts = 0, rsp_cyc = -10;
    logic prev_req = 1'b0, open_req = 1'b0, hs_prev = 1'b0, hs;
    logic rq, rv, rdy, exp_rdy;
    set_cmd(32'h0000_0100, 2'd2, 1'b1, 32'h1111_1111, 1'b0);
    out_resp_bits_data = 32'hCAFE_F00D;
    for (int c = 0; c < 12; c++) begin
      rq  = out_req_valid;
      rv  = rsp_valid;
      rdy = cmd_ready;
      out_resp_valid = prev_req;
      prev_req = rq;
      if (hs_prev) begin
        if (accepts == 1) set_cmd(32'h0000_0200, 2'd2, 1'b0, 32'h0, 1'b0);
        else cmd_valid = 1'b0;
      end
      if (rq) begin
        reqs++;
        vec_cnt++;
        if (open_req) begin
          miss_cnt++;
          $display("FAIL b2b_double_req: second request at cycle %0d without rsp_valid", c);
        end
        open_req = 1'b1;
      end
      if (rv) begin
        rsps++;
        open_req = 1'b0;
        rsp_cyc = c;
        vec_cnt++;
        if (rsp_data !== ((rsps == 2) ? 32'hCAFE_F00D : 32'h0)) begin
          miss_cnt++;
          $display("FAIL b2b_rsp_data[%0d]: got %h", rsps, rsp_data);
        end
      end
      exp_rdy = (c == 0) || (c == 4) || (c >= 8);
      vec_cnt++;
      if (rdy !== exp_rdy) begin
        miss_cnt++;
        $display("FAIL b2b_ready[%0d]: got %b expected %b", c, rdy, exp_rdy);
      end
      hs = rdy && cmd_valid;
      if (hs) begin
        accepts++;
        if (accepts == 2) begin
          vec_cnt++;
          if (c != rsp_cyc + 1) begin
            miss_cnt++;
            $display("FAIL b2b_second_accept: cycle %0d expected %0d", c, rsp_cyc + 1);
          end
        end
      end
      hs_prev = hs;
      @(negedge clock);
    end
    out_resp_valid = 1'b0;
    cmd_valid = 1'b0;
    vec_cnt++;
    if ({reqs, rsps, accepts} !== {32'd2, 32'd2, 32'd2}) begin
      miss_cnt++;
      $display("FAIL b2b_counts: reqs %0d rsps %0d accepts %0d expected 2 2 2", reqs, rsps, accepts);
    end
    $display("txn back-to-back: %0d requests, %0d completions", reqs, rsps);
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_loads();
    test_misaligned();
    test_timeout();
    test_resp_at_timeout();
    test_reset_in_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
